// File: rtl/canny_hysteresis.sv
// rtl/canny_hysteresis.sv - double-threshold + 8-neighbour hysteresis on streamed gradient magnitude
// Optional feature macro: CANNY_EDGE_COUNT_EN (adds edge_count output and per-frame edge counter)
module canny_hysteresis #(
    parameter int IMG_W = 240,
    parameter int IMG_H = 170
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mag_de,
    input  logic [7:0]  mag_data,
    input  logic [7:0]  thr_low,
    input  logic [7:0]  thr_high,
    output logic        canny_de,
    output logic [7:0]  canny_data,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
`ifdef CANNY_EDGE_COUNT_EN
    ,
    output logic [15:0] edge_count
`endif
);

    localparam int N    = IMG_W * IMG_H;
    localparam int CW   = $clog2(N);
    localparam int FW   = $clog2(IMG_W + 1);
    localparam int COLW = $clog2(IMG_W);
    localparam int ROWW = $clog2(IMG_H);
    localparam int HL   = 2 * IMG_W + 2;

    localparam logic [CW-1:0]   P_FIRST_OUT = CW'(IMG_W + 1);
    localparam logic [CW-1:0]   P_LAST      = CW'(N - 1);
    localparam logic [FW-1:0]   F_LAST      = FW'(IMG_W);
    localparam logic [COLW-1:0] COL_LAST    = COLW'(IMG_W - 1);
    localparam logic [ROWW-1:0] ROW_LAST    = ROWW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [7:0]      thr_lo_q, thr_lo_d;
    logic [7:0]      thr_hi_q, thr_hi_d;
    logic            canny_de_q, canny_de_d;
    logic            canny_bit_q, canny_bit_d;
    logic            fd_pend_q, fd_pend_d;
    logic            frame_done_q, frame_done_d;
    logic            overrun_q, overrun_d;

    logic            advance;
    logic            emit;
    logic            frame_start;
    logic [1:0]      code_in;
    logic            edge_bit;
    logic [1:0]      hist_q [0:HL-1];

    function automatic logic [1:0] classify(input logic [7:0] m, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (m >= hi)      return 2'd2;
        else if (m >= lo) return 2'd1;
        else              return 2'd0;
    endfunction

    // Window taps: code_in is (r+1,c+1); hist_q[k] is the pixel k+1 positions earlier,
    // so hist_q[IMG_W] is the centre (r,c).
    always_comb begin
        logic strong_nb;
        logic border;
        strong_nb = (code_in == 2'd2) ||
                    (hist_q[0] == 2'd2) || (hist_q[1] == 2'd2) ||
                    (hist_q[IMG_W-1] == 2'd2) || (hist_q[IMG_W+1] == 2'd2) ||
                    (hist_q[2*IMG_W-1] == 2'd2) || (hist_q[2*IMG_W] == 2'd2) ||
                    (hist_q[2*IMG_W+1] == 2'd2);
        border    = (row_q == '0) || (row_q == ROW_LAST) ||
                    (col_q == '0) || (col_q == COL_LAST);
        edge_bit  = 1'b0;
        if (!border) begin
            if (hist_q[IMG_W] == 2'd2)
                edge_bit = 1'b1;
            else if (hist_q[IMG_W] == 2'd1 && strong_nb)
                edge_bit = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        thr_lo_d     = thr_lo_q;
        thr_hi_d     = thr_hi_q;
        fd_pend_d    = 1'b0;
        frame_done_d = fd_pend_q;
        overrun_d    = overrun_q;
        advance      = 1'b0;
        emit         = 1'b0;
        frame_start  = 1'b0;
        code_in      = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (mag_de) begin
                    // Pixel 0 is classified against the thresholds being latched this cycle.
                    thr_lo_d    = thr_low;
                    thr_hi_d    = thr_high;
                    code_in     = classify(mag_data, thr_low, thr_high);
                    advance     = 1'b1;
                    frame_start = 1'b1;
                    in_cnt_d    = CW'(1);
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (mag_de) begin
                    code_in = classify(mag_data, thr_lo_q, thr_hi_q);
                    advance = 1'b1;
                    emit    = (in_cnt_q >= P_FIRST_OUT);
                    if (in_cnt_q == P_LAST) begin
                        in_cnt_d    = '0;
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                advance = 1'b1;
                emit    = 1'b1;
                if (mag_de)
                    overrun_d = 1'b1;
                if (flush_cnt_q == F_LAST) begin
                    fd_pend_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        canny_de_d  = emit;
        canny_bit_d = emit & edge_bit;
        if (emit) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            flush_cnt_q  <= '0;
            col_q        <= '0;
            row_q        <= '0;
            thr_lo_q     <= '0;
            thr_hi_q     <= '0;
            canny_de_q   <= 1'b0;
            canny_bit_q  <= 1'b0;
            fd_pend_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            thr_lo_q     <= thr_lo_d;
            thr_hi_q     <= thr_hi_d;
            canny_de_q   <= canny_de_d;
            canny_bit_q  <= canny_bit_d;
            fd_pend_q    <= fd_pend_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            hist_q[0] <= code_in;
            for (int i = 1; i < HL; i++)
                hist_q[i] <= hist_q[i-1];
        end
    end

    assign canny_de   = canny_de_q;
    assign canny_data = {8{canny_bit_q}};
    assign frame_done = frame_done_q;
    assign busy       = (state_q == S_FLUSH);
    assign overrun    = overrun_q;

`ifdef CANNY_EDGE_COUNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;
    logic [15:0] edge_count_q, edge_count_d;

    always_comb begin
        edge_cnt_d   = edge_cnt_q;
        edge_count_d = edge_count_q;
        if (frame_start)
            edge_cnt_d = '0;
        else if (emit && edge_bit && edge_cnt_q != 16'hFFFF)
            edge_cnt_d = edge_cnt_q + 16'd1;
        if (fd_pend_q)
            edge_count_d = edge_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt_q   <= '0;
            edge_count_q <= '0;
        end else begin
            edge_cnt_q   <= edge_cnt_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign edge_count = edge_count_q;
`endif

endmodule

// File: tb/tb_canny_hysteresis.sv
// tb/tb_canny_hysteresis.sv - self-checking bench for canny_hysteresis (8x6 frames)
module tb_canny_hysteresis;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mag_de = 1'b0;
    logic [7:0] mag_data = 8'd0;
    logic [7:0] thr_low = 8'd0;
    logic [7:0] thr_high = 8'd0;
    logic       canny_de;
    logic [7:0] canny_data;
    logic       frame_done;
    logic       busy;
    logic       overrun;
`ifdef CANNY_EDGE_COUNT_EN
    logic [15:0] edge_count;
`endif

    canny_hysteresis #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .mag_de     (mag_de),
        .mag_data   (mag_data),
        .thr_low    (thr_low),
        .thr_high   (thr_high),
        .canny_de   (canny_de),
        .canny_data (canny_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
`ifdef CANNY_EDGE_COUNT_EN
        ,
        .edge_count (edge_count)
`endif
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] got [$];
    int         got_cyc [$];
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (canny_de) begin
            got.push_back(canny_data);
            got_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [7:0] img [0:N-1];
    logic [7:0] expv [0:N-1];
    int         drive9_cyc;
    int         last_base;

    // Reference: classify every pixel, then apply the border and single-pass hysteresis rules.
    function automatic int model(input int lo, input int hi);
        int code [0:H-1][0:W-1];
        int edges = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                code[r][c] = (img[r*W+c] >= hi) ? 2 : (img[r*W+c] >= lo) ? 1 : 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                bit on = 0;
                if (r > 0 && r < H-1 && c > 0 && c < W-1) begin
                    if (code[r][c] == 2) on = 1;
                    else if (code[r][c] == 1)
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if (code[r+dr][c+dc] == 2) on = 1;
                end
                expv[r*W+c] = on ? 8'hFF : 8'h00;
                edges += on;
            end
        return edges;
    endfunction

    // gap < 0 selects a random 0..2 idle gap after each pixel; extra = mag_de cycles after the last pixel.
    task automatic run_frame(input string name, input int gap, input int lo, input int hi,
                             input int extra, output int edges_got);
        int base, fd0, wd, g, exp_edges;
        base = got.size();
        fd0 = fd_cnt;
        for (int p = 0; p < N; p++) begin
            @(negedge clk);
            mag_de   = 1'b1;
            mag_data = img[p];
            thr_low  = (p == 0) ? 8'(lo) : 8'($urandom);
            thr_high = (p == 0) ? 8'(hi) : 8'($urandom);
            if (p == 9) drive9_cyc = cyc;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                mag_de = 1'b0;
            end
        end
        for (int e = 0; e < extra; e++) begin
            @(negedge clk);
            mag_de   = 1'b1;
            mag_data = 8'h77;
        end
        @(negedge clk);
        mag_de = 1'b0;
        wd = 0;
        while (fd_cnt == fd0 && wd < 300) begin
            @(negedge clk);
            wd++;
        end
        chk({name, " frame_done seen"}, fd_cnt - fd0, 1);
        @(negedge clk);
        exp_edges = model(lo, hi);
        chk({name, " output count"}, got.size() - base, N);
        edges_got = 0;
        for (int q = 0; q < N && base + q < got.size(); q++) begin
            if (got[base+q] == 8'hFF) edges_got++;
            if (got[base+q] != expv[q]) begin
                chk($sformatf("%s pixel %0d", name, q), got[base+q], expv[q]);
            end else begin
                n_cmp++;
            end
        end
`ifdef CANNY_EDGE_COUNT_EN
        chk({name, " edge_count"}, edge_count, exp_edges);
`endif
        last_base = base;
    endtask

    typedef struct {
        int lo, hi;
        int pa, ma, pb, mb;
        int exp_edges;
        int exp_pa;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int eg, b0, base;

        vecs[0]  = '{10, 40, -1, 0,     -1, 0,     0, 0};
        vecs[1]  = '{10, 40, 19, 8'h50, -1, 0,     1, 255};
        vecs[2]  = '{10, 40, 19, 8'h20, 28, 8'h50, 2, 255};
        vecs[3]  = '{10, 40, 19, 8'h20, -1, 0,     0, 0};
        vecs[4]  = '{10, 40,  3, 8'hFF, -1, 0,     0, 0};
        vecs[5]  = '{10, 40, 23, 8'hFF, -1, 0,     0, 0};
        vecs[6]  = '{10, 40, 11, 8'h20,  3, 8'h50, 1, 255};
        vecs[7]  = '{10, 40, 19, 8'h20, 28, 8'h20, 0, 0};
        vecs[8]  = '{10, 40, 19, 8'h20, 37, 8'h50, 1, 0};
        vecs[9]  = '{60, 40, 19, 8'h20, 28, 8'h28, 1, 0};
        vecs[10] = '{10, 40, 19, 8'h28, -1, 0,     1, 255};
        vecs[11] = '{10, 40, 19, 8'h27, -1, 0,     0, 0};
        vecs[12] = '{10, 40, 19, 8'h0A, 28, 8'h50, 2, 255};
        vecs[13] = '{10, 40, 19, 8'h09, 28, 8'h50, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset canny_de", canny_de, 0);
        chk("reset canny_data", canny_data, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero frame back-to-back: latency, busy length, frame_done timing.
        for (int p = 0; p < N; p++) img[p] = 8'h00;
        b0 = busy_cnt;
        run_frame("zeros", 0, 10, 40, 0, eg);
        chk("zeros edges", eg, 0);
        chk("zeros busy cycles", busy_cnt - b0, W + 1);
        chk("zeros first output latency", got_cyc[last_base] - drive9_cyc, 1);
        chk("zeros frame_done after last", fd_cyc - got_cyc[last_base+N-1], 1);

        for (int v = 0; v < 14; v++) begin
            for (int p = 0; p < N; p++) img[p] = 8'h00;
            if (vecs[v].pa >= 0) img[vecs[v].pa] = 8'(vecs[v].ma);
            if (vecs[v].pb >= 0) img[vecs[v].pb] = 8'(vecs[v].mb);
            run_frame($sformatf("vec%0d", v), 0, vecs[v].lo, vecs[v].hi, 0, eg);
            chk($sformatf("vec%0d edges", v), eg, vecs[v].exp_edges);
            if (vecs[v].pa >= 0)
                chk($sformatf("vec%0d centre", v), got[last_base+vecs[v].pa], vecs[v].exp_pa);
        end

        // Strong pixels only on row 0 and column 7.
        for (int p = 0; p < N; p++) img[p] = ((p < W) || (p % W == W-1)) ? 8'hFF : 8'h00;
        run_frame("border", 1, 10, 40, 0, eg);
        chk("border edges", eg, 0);

        // Random magnitudes, mag_de every 3rd cycle and random gaps.
        for (int f = 0; f < 4; f++) begin
            int lo, hi;
            lo = $urandom_range(20, 90);
            hi = $urandom_range(40, 140);
            for (int p = 0; p < N; p++) img[p] = 8'($urandom_range(0, 160));
            run_frame($sformatf("rand%0d", f), (f < 2) ? 2 : -1, lo, hi, 0, eg);
        end

        // mag_de during FLUSH is dropped and flagged.
        for (int p = 0; p < N; p++) img[p] = 8'($urandom_range(0, 160));
        run_frame("overrun", 0, 30, 70, 3, eg);
        chk("overrun flag", overrun, 1);

        // Abort mid-frame with reset; the next frame must be clean.
        b0 = fd_cnt;
        base = got.size();
        for (int p = 0; p < 20; p++) begin
            @(negedge clk);
            mag_de   = 1'b1;
            mag_data = 8'hFF;
            thr_low  = 8'd10;
            thr_high = 8'd40;
        end
        @(negedge clk);
        mag_de = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("midreset overrun cleared", overrun, 0);
        chk("midreset canny_de", canny_de, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset no frame_done", fd_cnt - b0, 0);
        chk("midreset partial outputs", got.size() - base, 20 - (W + 1));
        for (int p = 0; p < N; p++) img[p] = 8'($urandom_range(0, 160));
        run_frame("after_reset", 0, 25, 60, 0, eg);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
